// File: rtl/round_timer_if.sv
// round_timer_if: control pulses and display/status bundle of the round timer.
// master drives Tick/Start/PauseToggle; slave (the timer) drives digits and flags.
interface round_timer_if;
    logic       Tick;
    logic       Start;
    logic       PauseToggle;
    logic [3:0] TensDigit;
    logic [3:0] OnesDigit;
    logic       Running;
    logic       Paused;
    logic       Expired;
    logic       TimeUp;
    logic       Warning;

    modport master (
        output Tick, Start, PauseToggle,
        input  TensDigit, OnesDigit, Running, Paused,
        input  Expired, TimeUp, Warning
    );

    modport slave (
        input  Tick, Start, PauseToggle,
        output TensDigit, OnesDigit, Running, Paused,
        output Expired, TimeUp, Warning
    );
endinterface

// File: rtl/round_timer.sv
// round_timer: two-digit BCD game-round countdown driven by a 1 Hz Tick.
// Ports: ClockIn, Reset (sync, active-high), bus (round_timer_if.slave):
//   Tick/Start/PauseToggle pulses in; TensDigit/OnesDigit BCD out;
//   Running/Paused/Expired state decode, TimeUp entry pulse, Warning window.
module round_timer #(
    parameter int START_SECONDS = 60,
    parameter int WARN_SECONDS  = 10
) (
    input  logic         ClockIn,
    input  logic         Reset,
    round_timer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        PAUSED  = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    localparam logic [3:0] LOAD_TENS = 4'(START_SECONDS / 10);
    localparam logic [3:0] LOAD_ONES = 4'(START_SECONDS % 10);
    localparam logic [6:0] WARN_MAX  = 7'(WARN_SECONDS);

    state_t     state_q, state_d;
    logic [3:0] tens_q, tens_d;
    logic [3:0] ones_q, ones_d;
    logic       timeup_q, timeup_d;
    logic [6:0] remaining;

    always_ff @(posedge ClockIn) begin
        if (Reset) begin
            state_q  <= IDLE;
            tens_q   <= LOAD_TENS;
            ones_q   <= LOAD_ONES;
            timeup_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            tens_q   <= tens_d;
            ones_q   <= ones_d;
            timeup_q <= timeup_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        tens_d   = tens_q;
        ones_d   = ones_q;
        timeup_d = 1'b0;
        if (bus.Start) begin
            // Reload wins over any coincident Tick or PauseToggle.
            state_d = RUNNING;
            tens_d  = LOAD_TENS;
            ones_d  = LOAD_ONES;
        end else begin
            unique case (state_q)
                RUNNING: begin
                    if (bus.PauseToggle) begin
                        // A tick landing with the pause is dropped.
                        state_d = PAUSED;
                    end else if (bus.Tick) begin
                        if (tens_q == 4'd0 && ones_q == 4'd1) begin
                            ones_d   = 4'd0;
                            state_d  = EXPIRED;
                            timeup_d = 1'b1;
                        end else if (ones_q != 4'd0) begin
                            ones_d = ones_q - 4'd1;
                        end else begin
                            ones_d = 4'd9;
                            tens_d = tens_q - 4'd1;
                        end
                    end
                end
                PAUSED: begin
                    if (bus.PauseToggle) begin
                        state_d = RUNNING;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign remaining = ({3'd0, tens_q} * 7'd10) + {3'd0, ones_q};

    assign bus.TensDigit = tens_q;
    assign bus.OnesDigit = ones_q;
    assign bus.Running   = (state_q == RUNNING);
    assign bus.Paused    = (state_q == PAUSED);
    assign bus.Expired   = (state_q == EXPIRED);
    assign bus.TimeUp    = timeup_q;
    assign bus.Warning   = (state_q == RUNNING || state_q == PAUSED)
                         && (remaining != 7'd0)
                         && (remaining <= WARN_MAX);

endmodule

// File: tb/tb_round_timer.sv
// tb_round_timer: directed checks of round_timer (60/10 and 5/0 variants).
// Linear stimulus, immediate assertions at each comparison point.
module tb_round_timer;

    logic clk;
    logic rst;
    logic tick;
    logic start;
    logic ptog;
    int   errors;
    int   checks;

    round_timer_if ti ();
    round_timer_if t5 ();

    assign ti.Tick        = tick;
    assign ti.Start       = start;
    assign ti.PauseToggle = ptog;
    assign t5.Tick        = tick;
    assign t5.Start       = start;
    assign t5.PauseToggle = ptog;

    round_timer #(.START_SECONDS(60), .WARN_SECONDS(10)) dut (
        .ClockIn (clk),
        .Reset   (rst),
        .bus     (ti)
    );

    round_timer #(.START_SECONDS(5), .WARN_SECONDS(0)) dut5 (
        .ClockIn (clk),
        .Reset   (rst),
        .bus     (t5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic t, input logic s, input logic p);
        @(negedge clk);
        tick  = t;
        start = s;
        ptog  = p;
        @(posedge clk);
        #1;
        tick  = 1'b0;
        start = 1'b0;
        ptog  = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_main(input string tag, input int tn, input int on,
                            input logic r, input logic p, input logic e,
                            input logic tu, input logic w);
        chk({tag, ".tens"}, 8'(ti.TensDigit), 8'(tn));
        chk({tag, ".ones"}, 8'(ti.OnesDigit), 8'(on));
        chk({tag, ".flags"},
            {3'd0, ti.Running, ti.Paused, ti.Expired, ti.TimeUp, ti.Warning},
            {3'd0, r, p, e, tu, w});
    endtask

    initial begin
        errors = 0;
        checks = 0;
        tick   = 1'b0;
        start  = 1'b0;
        ptog   = 1'b0;
        rst    = 1'b1;
        step(0, 0, 0);
        step(0, 0, 0);
        chk_main("reset", 6, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) step(1, 0, 0);
        chk_main("idle_ticks", 6, 0, 0, 0, 0, 0, 0);

        step(0, 1, 0);
        chk_main("start", 6, 0, 1, 0, 0, 0, 0);
        step(1, 0, 0);
        chk_main("60to59", 5, 9, 1, 0, 0, 0, 0);
        step(1, 0, 0);
        step(1, 0, 0);
        chk_main("three_ticks", 5, 7, 1, 0, 0, 0, 0);

        // 57 -> 11 takes 46 ticks; ones must stay valid BCD throughout
        for (int i = 0; i < 46; i++) begin
            step(1, 0, 0);
            chk("bcd_ones", 8'(ti.OnesDigit <= 4'd9), 8'd1);
        end
        chk_main("at11", 1, 1, 1, 0, 0, 0, 0);
        step(1, 0, 0);
        chk_main("at10", 1, 0, 1, 0, 0, 0, 1);
        step(1, 0, 0);
        chk_main("at09", 0, 9, 1, 0, 0, 0, 1);

        step(0, 0, 1);
        chk_main("pause09", 0, 9, 0, 1, 0, 0, 1);
        for (int i = 0; i < 4; i++) step(1, 0, 0);
        chk_main("paused_ticks", 0, 9, 0, 1, 0, 0, 1);
        step(0, 0, 1);
        chk_main("resume", 0, 9, 1, 0, 0, 0, 1);
        step(1, 0, 0);
        chk_main("resume_tick", 0, 8, 1, 0, 0, 0, 1);

        for (int i = 0; i < 7; i++) step(1, 0, 0);
        chk_main("at01", 0, 1, 1, 0, 0, 0, 1);
        step(1, 0, 0);
        chk_main("expire", 0, 0, 0, 0, 1, 1, 0);
        step(0, 0, 0);
        chk_main("timeup_once", 0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0);
            chk_main("expired_tick", 0, 0, 0, 0, 1, 0, 0);
        end
        step(0, 0, 1);
        chk_main("expired_pause", 0, 0, 0, 0, 1, 0, 0);

        step(0, 1, 0);
        for (int i = 0; i < 55; i++) step(1, 0, 0);
        chk_main("at05", 0, 5, 1, 0, 0, 0, 1);
        step(1, 1, 0);
        chk_main("start_tick", 6, 0, 1, 0, 0, 0, 0);
        step(0, 1, 1);
        chk_main("start_pause", 6, 0, 1, 0, 0, 0, 0);

        for (int i = 0; i < 30; i++) step(1, 0, 0);
        chk_main("at30", 3, 0, 1, 0, 0, 0, 0);
        step(1, 0, 1);
        chk_main("pause_tick", 3, 0, 0, 1, 0, 0, 0);

        step(0, 1, 0);
        for (int i = 0; i < 18; i++) step(1, 0, 0);
        chk_main("at42", 4, 2, 1, 0, 0, 0, 0);
        rst = 1'b1;
        step(1, 0, 0);
        chk_main("reset_mid", 6, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        step(0, 0, 0);
        chk_main("post_reset", 6, 0, 0, 0, 0, 0, 0);

        chk("s5.reset_ones", 8'(t5.OnesDigit), 8'd5);
        step(0, 1, 0);
        chk("s5.start",
            {t5.TensDigit, t5.OnesDigit}, 8'h05);
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 0);
            chk("s5.warn", {7'd0, t5.Warning}, 8'd0);
            chk("s5.ones", 8'(t5.OnesDigit), 8'(4 - i));
            chk("s5.run", {6'd0, t5.Running, t5.Expired}, 8'b10);
        end
        step(1, 0, 0);
        chk("s5.expire",
            {4'd0, t5.Expired, t5.TimeUp, t5.Warning, t5.Running}, 8'b1100);
        chk("s5.digits", {t5.TensDigit, t5.OnesDigit}, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/round_timer.md
Name: round_timer

Overview:
- Game-round countdown timer. Consumes the one-cycle seconds Tick produced by the rate divider and counts remaining round time down in two-digit BCD.
- Digits feed the HEX display decoders.
- Expiry flags feed the game FSM, which ends the round and changes screen.
- Start/pause are single-cycle pulses from the debounced key-input logic.

Parameters:
- START_SECONDS, 60, round length in seconds; legal range 1..99.
- WARN_SECONDS, 10, Warning asserts when remaining time is ≤ this value; legal range 0..START_SECONDS.

Ports:
- ClockIn  input  1  system clock (50 MHz).
- Reset  input  1  synchronous, active-high reset.
- Tick  input  1  one-cycle enable pulse, once per second, from the rate divider.
- Start  input  1  one-cycle pulse: load START_SECONDS and run.
- PauseToggle  input  1  one-cycle pulse: toggle between RUNNING and PAUSED.
- TensDigit  output  4  BCD tens digit of remaining seconds.
- OnesDigit  output  4  BCD ones digit of remaining seconds.
- Running  output  1  high while in RUNNING.
- Paused  output  1  high while in PAUSED.
- Expired  output  1  high while in EXPIRED.
- TimeUp  output  1  one-cycle pulse on entry to EXPIRED.
- Warning  output  1  remaining time is in the warning window.

Behaviour:
- Reset and register timing:
  - Reset is synchronous and active-high, on clock ClockIn.
  - All outputs and state are registered and update on the rising edge of ClockIn.
  - Reset has priority over every other input.
- Reset values:
  - State = IDLE.
  - TensDigit/OnesDigit = BCD of START_SECONDS (60 → 6, 0).
  - Running = Paused = Expired = TimeUp = Warning = 0.
- States: IDLE, RUNNING, PAUSED, EXPIRED.
- Start (any state):
  - Reload digits with START_SECONDS and go to RUNNING on the same edge.
  - Start wins over a coincident Tick and over a coincident PauseToggle; both are ignored that cycle.
- PauseToggle (Start low):
  - RUNNING → PAUSED; PAUSED → RUNNING.
  - Ignored in IDLE and EXPIRED.
  - If PauseToggle and Tick coincide in RUNNING, the pause takes effect and the tick is discarded.
  - Digits never change in PAUSED.
- Tick in RUNNING (Start and PauseToggle low), BCD decrement:
  - If OnesDigit ≠ 0: OnesDigit − 1.
  - Otherwise: OnesDigit = 9, TensDigit − 1.
  - Decrement is never binary; digits stay 0..9 at all times.
  - If remaining = 01 at the tick: digits become 0, 0; state → EXPIRED; TimeUp = 1 for exactly that next cycle.
- Tick in IDLE, PAUSED or EXPIRED: ignored.
- Latency: new digits are visible one cycle after the edge at which Tick is sampled high. No other pipeline delay.
- EXPIRED:
  - Digits hold at 0, 0; Expired held high.
  - Left only by Start (→ RUNNING with reload) or Reset (→ IDLE).
  - TimeUp does not re-fire while remaining in EXPIRED.
- Status outputs:
  - Running/Paused/Expired are a one-hot decode of the state register; all are low in IDLE.
- Warning:
  - Asserted when state is RUNNING or PAUSED and 1 ≤ remaining ≤ WARN_SECONDS.
  - Low in IDLE and EXPIRED.
  - Decoded from registered digits/state, so it changes in the same cycle as the digits.
- Tick phase: Tick is free-running and not aligned to Start, so the first second after Start may be 1 to 50,000,000 cycles long. This is accepted behaviour; the timer does not reset the rate divider.
- Tick pulse length: a Tick held high for N cycles decrements N times. Callers must drive single-cycle pulses, which the rate divider guarantees.
- Reset mid-run: returns to IDLE with reload values on the next edge. No TimeUp is generated.

Test Plan:
- Reset, then idle 5 cycles with Tick pulses → state IDLE, digits 6, 0, all flags 0, no decrement.
- Start, then 3 Ticks → digits 5, 7; Running = 1. Check the 60 → 59 transition gives tens 5, ones 9, with no invalid BCD (ones never shows A–F).
- Run to 11, 10, 09 → Warning low at 11, high at 10 and 09. PauseToggle at 09 → Paused = 1, Warning stays 1, 4 Ticks leave 0, 9. PauseToggle again → resumes at 0, 9 on the next Tick.
- Tick at remaining 01 → digits 0, 0; Expired = 1; TimeUp high for exactly one cycle. Further Ticks → no change and no second TimeUp.
- Coincident events:
  - Start + Tick at remaining 05 → reload to 6, 0.
  - Start + PauseToggle → Running = 1.
  - PauseToggle + Tick at 30 → Paused with 3, 0.
- Reset asserted mid-run at 42 → next cycle IDLE with 6, 0, flags 0, no TimeUp. Repeat the run with START_SECONDS = 5 and WARN_SECONDS = 0 → Warning never asserts; expires after 5 Ticks.
